// File: rtl/frota_pkg.sv
// Shared state type, default formation geometry and small index/count helpers
// for the enemy-fleet controller.
package frota_pkg;

  typedef enum logic [1:0] {
    MARCH   = 2'd0,
    CLEARED = 2'd1,
    INVADED = 2'd2
  } frota_state_t;

  localparam int DEF_N_ROWS      = 4;
  localparam int DEF_N_COLS      = 5;
  localparam int DEF_X0          = 60;
  localparam int DEF_Y0          = 40;
  localparam int DEF_DX          = 50;
  localparam int DEF_DY          = 40;
  localparam int DEF_W           = 30;
  localparam int DEF_H           = 20;
  localparam int DEF_STEP_X      = 4;
  localparam int DEF_DROP_Y      = 10;
  localparam int DEF_X_MAX       = 639;
  localparam int DEF_Y_LIMIT     = 400;
  localparam int DEF_SPEED_SHIFT = 2;

  function automatic int idx_row(input int idx, input int n_cols);
    return idx / n_cols;
  endfunction

  function automatic int idx_col(input int idx, input int n_cols);
    return idx % n_cols;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) cnt = cnt + int'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/frota_colisao.sv
// Combinational bullet-vs-formation test; the lowest-index live enemy whose
// box contains the bullet point wins.
module frota_colisao
  import frota_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS,
  parameter int DX     = DEF_DX,
  parameter int DY     = DEF_DY,
  parameter int W      = DEF_W,
  parameter int H      = DEF_H,
  parameter int N      = N_ROWS * N_COLS,
  parameter int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [9:0]    fleet_x,
  input  logic [9:0]    fleet_y,
  input  logic [N-1:0]  vivo,
  input  logic [9:0]    bola_x,
  input  logic [9:0]    bola_y,
  input  logic          bola_valid,
  output logic          hit_any,
  output logic [IW-1:0] hit_idx
);

  logic [10:0] px, py, box_x, box_y;

  assign px = {1'b0, bola_x};
  assign py = {1'b0, bola_y};

  // Scan from the top index down so the last match written is the lowest index.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    box_x   = '0;
    box_y   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      box_x = {1'b0, fleet_x} + 11'(idx_col(i, N_COLS) * DX);
      box_y = {1'b0, fleet_y} + 11'(idx_row(i, N_COLS) * DY);
      if (bola_valid && vivo[i] &&
          px >= box_x && px < box_x + 11'(W) &&
          py >= box_y && py < box_y + 11'(H)) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/frota_parametrizada.sv
// Enemy-fleet controller: marches an N_ROWS x N_COLS formation, resolves
// bullet hits, and reports wave-clear and invasion.
//
// state   | meaning
// MARCH   | formation alive, marching and taking hits
// CLEARED | last enemy killed, waiting for a tick to reload the wave
// INVADED | live row crossed the invasion line, everything frozen
module frota_parametrizada
  import frota_pkg::*;
#(
  parameter int N_ROWS      = DEF_N_ROWS,
  parameter int N_COLS      = DEF_N_COLS,
  parameter int X0          = DEF_X0,
  parameter int Y0          = DEF_Y0,
  parameter int DX          = DEF_DX,
  parameter int DY          = DEF_DY,
  parameter int W           = DEF_W,
  parameter int H           = DEF_H,
  parameter int STEP_X      = DEF_STEP_X,
  parameter int DROP_Y      = DEF_DROP_Y,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_LIMIT     = DEF_Y_LIMIT,
  parameter int SPEED_SHIFT = DEF_SPEED_SHIFT,
  parameter int N           = N_ROWS * N_COLS,
  parameter int IW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          tick_mv,
  input  logic          pausa,
  input  logic          reiniciarJogo,
  input  logic [9:0]    bola_nave_x,
  input  logic [9:0]    bola_nave_y,
  input  logic          bola_nave_valid,
  output logic [9:0]    fleet_x,
  output logic [9:0]    fleet_y,
  output logic          dir,
  output logic [N-1:0]  vivo,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output logic [7:0]    n_batidas,
  output logic          wave_clear,
  output logic          invadido
);

  localparam logic [N-1:0] ALL_ALIVE = '1;
  localparam logic [N-1:0] ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  frota_state_t state, state_nx;
  logic [9:0]    fleet_x_nx, fleet_y_nx;
  logic          dir_nx, hit_nx, wave_nx, inv_nx;
  logic [N-1:0]  vivo_nx;
  logic [IW-1:0] hit_idx_nx, col_idx;
  logic [7:0]    n_nx, tick_cnt, tick_cnt_nx, k_val;
  logic          hit_any;
  logic [N_COLS-1:0] col_alive;
  logic [N_ROWS-1:0] row_alive;
  logic [10:0]   off_l, off_r, off_b, x_ext, y_drop;
  logic          edge_r, edge_l, invade;
  int            alive_cnt;

  frota_colisao #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DX(DX), .DY(DY), .W(W), .H(H), .N(N), .IW(IW)
  ) u_colisao (
    .fleet_x   (fleet_x),
    .fleet_y   (fleet_y),
    .vivo      (vivo),
    .bola_x    (bola_nave_x),
    .bola_y    (bola_nave_y),
    .bola_valid(bola_nave_valid),
    .hit_any   (hit_any),
    .hit_idx   (col_idx)
  );

  always_comb begin
    col_alive = '0;
    row_alive = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (vivo[r*N_COLS + c]) begin
          col_alive[c] = 1'b1;
          row_alive[r] = 1'b1;
        end
      end
    end
  end

  // Pixel offsets of the live extent: leftmost/rightmost column, lowest row.
  always_comb begin
    off_l = '0;
    off_r = '0;
    off_b = '0;
    for (int c = N_COLS - 1; c >= 0; c--) if (col_alive[c]) off_l = 11'(c * DX);
    for (int c = 0; c < N_COLS; c++)      if (col_alive[c]) off_r = 11'(c * DX);
    for (int r = 0; r < N_ROWS; r++)      if (row_alive[r]) off_b = 11'(r * DY);
  end

  always_comb begin
    alive_cnt = popcount(64'(vivo));
    k_val     = 8'(alive_cnt >> SPEED_SHIFT);
    if (k_val == 8'd0) k_val = 8'd1;
  end

  assign x_ext  = {1'b0, fleet_x};
  assign y_drop = {1'b0, fleet_y} + 11'(DROP_Y);
  assign edge_r = dir  && (x_ext + off_r + 11'(W) + 11'(STEP_X) > 11'(X_MAX));
  assign edge_l = !dir && (x_ext + off_l < 11'(STEP_X));
  assign invade = (y_drop + off_b + 11'(H) >= 11'(Y_LIMIT));

  always_comb begin
    state_nx    = state;
    fleet_x_nx  = fleet_x;
    fleet_y_nx  = fleet_y;
    dir_nx      = dir;
    vivo_nx     = vivo;
    hit_nx      = 1'b0;
    hit_idx_nx  = hit_idx;
    n_nx        = n_batidas;
    wave_nx     = 1'b0;
    inv_nx      = invadido;
    tick_cnt_nx = tick_cnt;
    unique case (state)
      MARCH: begin
        if (!pausa) begin
          if (hit_any) begin
            vivo_nx    = vivo & ~(ONE_HOT0 << col_idx);
            hit_nx     = 1'b1;
            hit_idx_nx = col_idx;
            if (n_batidas != 8'hFF) n_nx = n_batidas + 8'd1;
          end
          // Speed and edges use the pre-kill mask; a final kill pre-empts the move.
          if (hit_any && alive_cnt == 1) begin
            wave_nx  = 1'b1;
            state_nx = CLEARED;
          end else if (tick_mv) begin
            if (tick_cnt + 8'd1 >= k_val) begin
              tick_cnt_nx = '0;
              if (edge_r || edge_l) begin
                fleet_y_nx = 10'(y_drop);
                dir_nx     = !dir;
                if (invade) begin
                  state_nx = INVADED;
                  inv_nx   = 1'b1;
                end
              end else if (dir) begin
                fleet_x_nx = 10'(x_ext + 11'(STEP_X));
              end else begin
                fleet_x_nx = 10'(x_ext - 11'(STEP_X));
              end
            end else begin
              tick_cnt_nx = tick_cnt + 8'd1;
            end
          end
        end
      end
      CLEARED: begin
        if (!pausa && tick_mv) begin
          fleet_x_nx  = 10'(X0);
          fleet_y_nx  = 10'(Y0);
          dir_nx      = 1'b1;
          vivo_nx     = ALL_ALIVE;
          tick_cnt_nx = '0;
          state_nx    = MARCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciarJogo) begin
      state      <= MARCH;
      fleet_x    <= 10'(X0);
      fleet_y    <= 10'(Y0);
      dir        <= 1'b1;
      vivo       <= ALL_ALIVE;
      hit        <= 1'b0;
      hit_idx    <= '0;
      n_batidas  <= '0;
      wave_clear <= 1'b0;
      invadido   <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      state      <= state_nx;
      fleet_x    <= fleet_x_nx;
      fleet_y    <= fleet_y_nx;
      dir        <= dir_nx;
      vivo       <= vivo_nx;
      hit        <= hit_nx;
      hit_idx    <= hit_idx_nx;
      n_batidas  <= n_nx;
      wave_clear <= wave_nx;
      invadido   <= inv_nx;
      tick_cnt   <= tick_cnt_nx;
    end
  end

endmodule

// File: tb/tb_frota_parametrizada.sv
// Self-checking bench for the fleet controller with default geometry.
module tb_frota_parametrizada;

  localparam int N = 20;

  logic          CLOCK_50 = 1'b0;
  logic          reset, tick_mv, pausa, reiniciarJogo, bola_nave_valid;
  logic [9:0]    bola_nave_x, bola_nave_y, fleet_x, fleet_y;
  logic          dir, hit, wave_clear, invadido;
  logic [N-1:0]  vivo;
  logic [4:0]    hit_idx;
  logic [7:0]    n_batidas;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  frota_parametrizada dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .tick_mv        (tick_mv),
    .pausa          (pausa),
    .reiniciarJogo  (reiniciarJogo),
    .bola_nave_x    (bola_nave_x),
    .bola_nave_y    (bola_nave_y),
    .bola_nave_valid(bola_nave_valid),
    .fleet_x        (fleet_x),
    .fleet_y        (fleet_y),
    .dir            (dir),
    .vivo           (vivo),
    .hit            (hit),
    .hit_idx        (hit_idx),
    .n_batidas      (n_batidas),
    .wave_clear     (wave_clear),
    .invadido       (invadido)
  );

  typedef struct {
    logic        pausa;
    logic        valid;
    logic [9:0]  bx;
    logic [9:0]  by;
    logic        exp_hit;
    logic [4:0]  exp_idx;
    logic [7:0]  exp_n;
    logic [19:0] exp_vivo;
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic tick();
    tick_mv = 1'b1;
    cyc();
    tick_mv = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Drive one bullet sample, queue its expectation, compare one cycle later.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    pausa           = v.pausa;
    bola_nave_valid = v.valid;
    bola_nave_x     = v.bx;
    bola_nave_y     = v.by;
    sb.push_back(v);
    cyc();
    e = sb.pop_front();
    check({tag, " hit"}, 32'(hit), 32'(e.exp_hit));
    if (e.exp_hit) check({tag, " hit_idx"}, 32'(hit_idx), 32'(e.exp_idx));
    check({tag, " n_batidas"}, 32'(n_batidas), 32'(e.exp_n));
    check({tag, " vivo"}, 32'(vivo), 32'(e.exp_vivo));
  endtask

  // Kill enemy i assuming the formation sits at the reset origin.
  function automatic vec_t kill_vec(input int i, input int n, input logic [19:0] v);
    vec_t k;
    k.pausa    = 1'b0;
    k.valid    = 1'b1;
    k.bx       = 10'(65 + 50 * (i % 5));
    k.by       = 10'(45 + 40 * (i / 5));
    k.exp_hit  = 1'b1;
    k.exp_idx  = 5'(i);
    k.exp_n    = 8'(n);
    k.exp_vivo = v;
    return k;
  endfunction

  task automatic idle_bullet();
    bola_nave_valid = 1'b0;
    pausa           = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " fleet_x"}, 32'(fleet_x), 32'd60);
    check({tag, " fleet_y"}, 32'(fleet_y), 32'd40);
    check({tag, " dir"}, 32'(dir), 32'd1);
    check({tag, " vivo"}, 32'(vivo), 32'hFFFFF);
    check({tag, " n_batidas"}, 32'(n_batidas), 32'd0);
    check({tag, " invadido"}, 32'(invadido), 32'd0);
    check({tag, " hit"}, 32'(hit), 32'd0);
    check({tag, " wave_clear"}, 32'(wave_clear), 32'd0);
  endtask

  initial begin
    logic [19:0] ev;
    int          n, t;
    vec_t        v;

    reset = 1'b1; tick_mv = 1'b0; pausa = 1'b0; reiniciarJogo = 1'b0;
    bola_nave_valid = 1'b0; bola_nave_x = '0; bola_nave_y = '0;

    //                pausa valid  bx   by   hit idx  n   vivo
    vecs[0]  = '{1'b0, 1'b1,  65,  45, 1'b1,  0, 1, 20'hFFFFE};
    vecs[1]  = '{1'b0, 1'b1,  65,  45, 1'b0,  0, 1, 20'hFFFFE};
    vecs[2]  = '{1'b0, 1'b1,  65,  45, 1'b0,  0, 1, 20'hFFFFE};
    vecs[3]  = '{1'b0, 1'b1,  65,  45, 1'b0,  0, 1, 20'hFFFFE};
    vecs[4]  = '{1'b0, 1'b1,  90,  45, 1'b0,  0, 1, 20'hFFFFE};
    vecs[5]  = '{1'b0, 1'b1, 110,  40, 1'b1,  1, 2, 20'hFFFFC};
    vecs[6]  = '{1'b0, 1'b1, 189,  59, 1'b1,  2, 3, 20'hFFFF8};
    vecs[7]  = '{1'b0, 1'b1, 190,  59, 1'b0,  0, 3, 20'hFFFF8};
    vecs[8]  = '{1'b0, 1'b1, 160,  60, 1'b0,  0, 3, 20'hFFFF8};
    vecs[9]  = '{1'b0, 1'b0, 260, 125, 1'b0,  0, 3, 20'hFFFF8};
    vecs[10] = '{1'b0, 1'b1, 260, 125, 1'b1, 14, 4, 20'hFBFF8};
    vecs[11] = '{1'b1, 1'b1,  65,  85, 1'b0,  0, 4, 20'hFBFF8};
    vecs[12] = '{1'b0, 1'b1,  65,  85, 1'b1,  5, 5, 20'hFBFD8};
    vecs[13] = '{1'b0, 1'b1, 160, 165, 1'b1, 17, 6, 20'hDBFD8};

    // Reset state
    do_reset();
    check_reset_vals("reset");

    // Collision table
    for (int k = 0; k < 14; k++) apply(vecs[k], $sformatf("vec%0d", k));
    idle_bullet();

    // March with all alive: K=5, pause discards ticks
    do_reset();
    ticks(4);
    check("k5 no move after 4", 32'(fleet_x), 32'd60);
    tick_mv = 1'b1;
    cyc();
    check("k5 move latency", 32'(fleet_x), 32'd64);
    tick_mv = 1'b0;
    cyc();
    pausa = 1'b1;
    ticks(10);
    pausa = 1'b0;
    check("pause march", 32'(fleet_x), 32'd64);
    ticks(430);
    check("march right x", 32'(fleet_x), 32'd408);
    check("march right y", 32'(fleet_y), 32'd40);
    check("march right dir", 32'(dir), 32'd1);
    ticks(5);
    check("drop x", 32'(fleet_x), 32'd408);
    check("drop y", 32'(fleet_y), 32'd50);
    check("drop dir", 32'(dir), 32'd0);

    // Columns 3-4 dead: cR=2, K=3
    do_reset();
    ev = 20'hFFFFF;
    n  = 0;
    foreach (vecs[k]) ;
    for (int i = 0; i < N; i++) begin
      if ((i % 5) >= 3) begin
        ev[i] = 1'b0;
        n++;
        apply(kill_vec(i, n, ev), $sformatf("colkill%0d", i));
      end
    end
    idle_bullet();
    check("colkill mask", 32'(vivo), 32'h39CE7);
    ticks(2);
    check("k3 no move after 2", 32'(fleet_x), 32'd60);
    tick();
    check("k3 move", 32'(fleet_x), 32'd64);
    ticks(333);
    check("narrow right x", 32'(fleet_x), 32'd508);
    check("narrow right dir", 32'(dir), 32'd1);
    ticks(3);
    check("narrow drop x", 32'(fleet_x), 32'd508);
    check("narrow drop y", 32'(fleet_y), 32'd50);
    check("narrow drop dir", 32'(dir), 32'd0);
    ticks(2);
    // Hit and move together: box judged at the pre-move origin
    tick_mv = 1'b1;
    v = '{1'b0, 1'b1, 535, 55, 1'b1, 0, 9, 20'h39CE6};
    apply(v, "hit+move");
    tick_mv = 1'b0;
    idle_bullet();
    check("hit+move x", 32'(fleet_x), 32'd504);

    // Wave clear, last kill on a tick cycle
    do_reset();
    ev = 20'hFFFFF;
    for (int i = 0; i < N - 1; i++) begin
      ev[i] = 1'b0;
      apply(kill_vec(i, i + 1, ev), $sformatf("wave%0d", i));
    end
    tick_mv = 1'b1;
    apply(kill_vec(19, 20, 20'h00000), "wave19");
    tick_mv = 1'b0;
    idle_bullet();
    check("wave_clear pulse", 32'(wave_clear), 32'd1);
    check("last kill no move", 32'(fleet_x), 32'd60);
    cyc();
    check("wave_clear one cycle", 32'(wave_clear), 32'd0);
    pausa = 1'b1;
    tick();
    pausa = 1'b0;
    check("cleared paused tick", 32'(vivo), 32'h00000);
    tick();
    check("reload vivo", 32'(vivo), 32'hFFFFF);
    check("reload x", 32'(fleet_x), 32'd60);
    check("reload y", 32'(fleet_y), 32'd40);
    check("reload dir", 32'(dir), 32'd1);
    check("reload keeps n", 32'(n_batidas), 32'd20);

    // Invasion with only enemy 15 (row 3, col 0) alive
    do_reset();
    ev = 20'hFFFFF;
    n  = 0;
    for (int i = 0; i < N; i++) begin
      if (i != 15) begin
        ev[i] = 1'b0;
        n++;
        apply(kill_vec(i, n, ev), $sformatf("invkill%0d", i));
      end
    end
    idle_bullet();
    t = 0;
    while (fleet_y !== 10'd250 && t < 10000) begin
      tick();
      t++;
    end
    check("reach y250 in budget", 32'(t < 10000), 32'd1);
    check("no early invasion", 32'(invadido), 32'd0);
    t = 0;
    while (invadido !== 1'b1 && t < 2000) begin
      tick();
      t++;
    end
    check("invasion in budget", 32'(t < 2000), 32'd1);
    check("invasion y", 32'(fleet_y), 32'd260);
    check("invasion x", 32'(fleet_x), 32'd0);
    check("invasion dir", 32'(dir), 32'd1);
    ticks(20);
    check("frozen x", 32'(fleet_x), 32'd0);
    check("frozen y", 32'(fleet_y), 32'd260);
    check("frozen invadido", 32'(invadido), 32'd1);
    v = '{1'b0, 1'b1, 5, 385, 1'b0, 0, 19, 20'h08000};
    apply(v, "frozen shot");
    idle_bullet();
    reiniciarJogo = 1'b1;
    cyc();
    reiniciarJogo = 1'b0;
    check_reset_vals("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
